// File: rtl/rpsc_seq_pkg.sv
// Shared types for the RPSC G1/anode high-voltage sequencer.
package rpsc_seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        G1_ON     = 3'd1,
        G1_SETTLE = 3'd2,
        AN_ON     = 3'd3,
        RUN       = 3'd4,
        AN_OFF    = 3'd5,
        FAULT     = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        FLT_NONE     = 3'd0,
        FLT_ALARM_G1 = 3'd1,
        FLT_ALARM_AN = 3'd2,
        FLT_G1_TMO   = 3'd3,
        FLT_TH_NRDY  = 3'd4,
        FLT_AN_TMO   = 3'd5,
        FLT_G1_LOST  = 3'd6,
        FLT_AN_LOST  = 3'd7
    } fault_e;

endpackage

// File: rtl/rpsc_seq_counter.sv
// Saturating phase counter with synchronous clear and a terminal compare.
module rpsc_seq_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [CNT_W-1:0] target,
    output logic [CNT_W-1:0] cnt,
    output logic             hit
);

    // Count up each cycle, hold at all-ones, restart from zero on clr.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (cnt != {CNT_W{1'b1}}) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign hit = (cnt == target);

endmodule

// File: rtl/rpsc_hv_sequencer.sv
// G1 grid / anode supply power sequencer with first-fault latch.
// Card-2 status inputs are level signals sampled every clock; there is no
// valid/ready handshake on this block, every input is considered valid on
// every rising edge of clk.
module rpsc_hv_sequencer
    import rpsc_seq_pkg::*;
#(
    parameter int CNT_W      = 4,
    parameter int G1_TIMEOUT = 12,
    parameter int SETTLE     = 4,
    parameter int AN_TIMEOUT = 14,
    parameter int AN_OFF_DLY = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_req,
    input  logic       stop_req,
    input  logic       fault_clr,
    input  logic       g1_not_alarm,
    input  logic       an_not_alarm,
    input  logic       g1_ok_n,
    input  logic       an_th_ready_n,
    input  logic       an_ok_n,
    output logic       g1_ps_act,
    output logic       an_ps_act,
    output logic       hv_ready,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [2:0] state
);

    state_e           state_q, state_nxt;
    fault_e           code_q, code_nxt;
    logic             g1_nxt, an_nxt, hv_nxt, fault_nxt;
    logic [CNT_W-1:0] cnt_tgt;
    logic [CNT_W-1:0] cnt;
    logic             cnt_hit;
    logic             cnt_clr;
    logic             alarm;
    fault_e           alarm_code;

    // Counter restarts on every state change and while in reset.
    assign cnt_clr = !reset || (state_nxt != state_q);

    rpsc_seq_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk    (clk),
        .clr    (cnt_clr),
        .target (cnt_tgt),
        .cnt    (cnt),
        .hit    (cnt_hit)
    );

    // G1 alarm is reported in preference to the anode alarm.
    assign alarm      = !g1_not_alarm || !an_not_alarm;
    assign alarm_code = !g1_not_alarm ? FLT_ALARM_G1 : FLT_ALARM_AN;

    // Next-state, fault code and next-output decode; priority is
    // alarm, then timeout/loss, then stop, then forward progress.
    always_comb begin
        state_nxt = state_q;
        code_nxt  = code_q;
        cnt_tgt   = '0;
        case (state_q)
            G1_ON:     cnt_tgt = CNT_W'(G1_TIMEOUT);
            G1_SETTLE: cnt_tgt = CNT_W'(SETTLE);
            AN_ON:     cnt_tgt = CNT_W'(AN_TIMEOUT);
            AN_OFF:    cnt_tgt = CNT_W'(AN_OFF_DLY);
            default:   cnt_tgt = '0;
        endcase

        case (state_q)
            IDLE: begin
                if (!stop_req && start_req && !alarm) state_nxt = G1_ON;
            end
            FAULT: begin
                if (fault_clr && !alarm) begin
                    state_nxt = IDLE;
                    code_nxt  = FLT_NONE;
                end
            end
            default: begin
                if (alarm) begin
                    state_nxt = FAULT;
                    code_nxt  = alarm_code;
                end else begin
                    case (state_q)
                        G1_ON: begin
                            if (cnt_hit) begin
                                state_nxt = FAULT;
                                code_nxt  = FLT_G1_TMO;
                            end else if (stop_req) begin
                                state_nxt = IDLE;
                            end else if (!g1_ok_n) begin
                                state_nxt = G1_SETTLE;
                            end
                        end
                        G1_SETTLE: begin
                            if (g1_ok_n) begin
                                state_nxt = FAULT;
                                code_nxt  = FLT_G1_LOST;
                            end else if (stop_req) begin
                                state_nxt = IDLE;
                            end else if (cnt_hit) begin
                                if (!an_th_ready_n) begin
                                    state_nxt = AN_ON;
                                end else begin
                                    state_nxt = FAULT;
                                    code_nxt  = FLT_TH_NRDY;
                                end
                            end
                        end
                        AN_ON: begin
                            if (cnt_hit) begin
                                state_nxt = FAULT;
                                code_nxt  = FLT_AN_TMO;
                            end else if (g1_ok_n) begin
                                state_nxt = FAULT;
                                code_nxt  = FLT_G1_LOST;
                            end else if (stop_req) begin
                                state_nxt = AN_OFF;
                            end else if (!an_ok_n) begin
                                state_nxt = RUN;
                            end
                        end
                        RUN: begin
                            if (g1_ok_n) begin
                                state_nxt = FAULT;
                                code_nxt  = FLT_G1_LOST;
                            end else if (an_ok_n) begin
                                state_nxt = FAULT;
                                code_nxt  = FLT_AN_LOST;
                            end else if (stop_req) begin
                                state_nxt = AN_OFF;
                            end
                        end
                        AN_OFF: begin
                            if (cnt_hit) state_nxt = IDLE;
                        end
                        default: state_nxt = FAULT;
                    endcase
                end
            end
        endcase

        g1_nxt    = (state_nxt == G1_ON) || (state_nxt == G1_SETTLE) ||
                    (state_nxt == AN_ON) || (state_nxt == RUN) ||
                    (state_nxt == AN_OFF);
        an_nxt    = (state_nxt == AN_ON) || (state_nxt == RUN);
        hv_nxt    = (state_nxt == RUN);
        fault_nxt = (state_nxt == FAULT);
    end

    // State, fault code and all outputs are registered together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            code_q    <= FLT_NONE;
            g1_ps_act <= 1'b0;
            an_ps_act <= 1'b0;
            hv_ready  <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            code_q    <= code_nxt;
            g1_ps_act <= g1_nxt;
            an_ps_act <= an_nxt;
            hv_ready  <= hv_nxt;
            fault     <= fault_nxt;
        end
    end

    assign fault_code = code_q;
    assign state      = state_q;

endmodule

// File: tb/tb_rpsc_hv_sequencer.sv
// Self-checking bench for rpsc_hv_sequencer.
module tb_rpsc_hv_sequencer;

  localparam int P_IDLE = 0, P_G1 = 1, P_SET = 2, P_AN = 3, P_RUN = 4, P_OFF = 5, P_FLT = 6;
  localparam int T_G1 = 12, T_SET = 4, T_AN = 14, T_OFF = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start_req = 1'b0, stop_req = 1'b0, fault_clr = 1'b0;
  logic g1_not_alarm = 1'b1, an_not_alarm = 1'b1;
  logic g1_ok_n = 1'b1, an_th_ready_n = 1'b1, an_ok_n = 1'b1;
  logic g1_ps_act, an_ps_act, hv_ready, fault;
  logic [2:0] fault_code, state;

  int n_cmp = 0;
  int n_mis = 0;
  logic [9:0] exp_q[$];

  int m_ph = P_IDLE;
  int m_dw = 0;
  int m_code = 0;

  rpsc_hv_sequencer dut (
    .clk(clk), .reset(reset), .start_req(start_req), .stop_req(stop_req),
    .fault_clr(fault_clr), .g1_not_alarm(g1_not_alarm), .an_not_alarm(an_not_alarm),
    .g1_ok_n(g1_ok_n), .an_th_ready_n(an_th_ready_n), .an_ok_n(an_ok_n),
    .g1_ps_act(g1_ps_act), .an_ps_act(an_ps_act), .hv_ready(hv_ready),
    .fault(fault), .fault_code(fault_code), .state(state)
  );

  // clock
  always #5 clk = ~clk;

  function automatic logic [9:0] pack_exp(int ph, int code);
    logic g1, an, hv, ft;
    g1 = (ph >= P_G1) && (ph <= P_OFF);
    an = (ph == P_AN) || (ph == P_RUN);
    hv = (ph == P_RUN);
    ft = (ph == P_FLT);
    return {g1, an, hv, ft, 3'(code), 3'(ph)};
  endfunction

  // behavioural model: phase plus cycles spent in it, stepped on each edge
  always @(posedge clk) begin
    int nph, ncode, ndw, acode;
    nph = m_ph;
    ncode = m_code;
    acode = !g1_not_alarm ? 1 : (!an_not_alarm ? 2 : 0);
    if (!reset) begin
      nph = P_IDLE;
      ncode = 0;
    end else if (m_ph == P_IDLE) begin
      if (!stop_req && start_req && acode == 0) nph = P_G1;
    end else if (m_ph == P_FLT) begin
      if (fault_clr && acode == 0) begin nph = P_IDLE; ncode = 0; end
    end else if (acode != 0) begin
      nph = P_FLT; ncode = acode;
    end else begin
      case (m_ph)
        P_G1:  if (m_dw == T_G1) begin nph = P_FLT; ncode = 3; end
               else if (stop_req) nph = P_IDLE;
               else if (!g1_ok_n) nph = P_SET;
        P_SET: if (g1_ok_n) begin nph = P_FLT; ncode = 6; end
               else if (stop_req) nph = P_IDLE;
               else if (m_dw == T_SET) begin
                 if (!an_th_ready_n) nph = P_AN; else begin nph = P_FLT; ncode = 4; end
               end
        P_AN:  if (m_dw == T_AN) begin nph = P_FLT; ncode = 5; end
               else if (g1_ok_n) begin nph = P_FLT; ncode = 6; end
               else if (stop_req) nph = P_OFF;
               else if (!an_ok_n) nph = P_RUN;
        P_RUN: if (g1_ok_n) begin nph = P_FLT; ncode = 6; end
               else if (an_ok_n) begin nph = P_FLT; ncode = 7; end
               else if (stop_req) nph = P_OFF;
        P_OFF: if (m_dw == T_OFF) nph = P_IDLE;
        default: nph = P_FLT;
      endcase
    end
    if (!reset || nph != m_ph) ndw = 0;
    else ndw = (m_dw < 15) ? m_dw + 1 : 15;
    m_ph <= nph;
    m_dw <= ndw;
    m_code <= ncode;
    exp_q.push_back(pack_exp(nph, ncode));
  end

  // scoreboard: every cycle, just after the edge
  initial begin
    forever begin
      logic [9:0] e, g;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = {g1_ps_act, an_ps_act, hv_ready, fault, fault_code, state};
        n_cmp++;
        if (g !== e) begin
          n_mis++;
          $display("FAIL cycle_check t=%0t got=%b exp=%b", $time, g, e);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_lit(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    start_req = 0; stop_req = 0; fault_clr = 0;
    g1_not_alarm = 1; an_not_alarm = 1;
    g1_ok_n = 1; an_th_ready_n = 1; an_ok_n = 1;
  endtask

  initial begin
    // reset
    tick(3);
    check_lit("reset_state", state, 0);
    check_lit("reset_g1", g1_ps_act, 0);
    check_lit("reset_code", fault_code, 0);
    reset = 1;
    tick(2);

    // nominal bring-up, cycle 0 = this negedge
    start_req = 1; an_th_ready_n = 0;
    tick(1);
    check_lit("nom_g1_c1", g1_ps_act, 1);
    check_lit("nom_state_c1", state, P_G1);
    tick(4);
    g1_ok_n = 0;
    tick(1);
    check_lit("nom_settle_c6", state, P_SET);
    tick(4);
    check_lit("nom_an_c10", an_ps_act, 0);
    tick(1);
    check_lit("nom_an_c11", an_ps_act, 1);
    tick(2);
    an_ok_n = 0;
    tick(1);
    check_lit("nom_hv_c14", hv_ready, 1);

    // controlled stop from RUN
    start_req = 0; stop_req = 1;
    tick(1);
    check_lit("stop_an", an_ps_act, 0);
    check_lit("stop_g1", g1_ps_act, 1);
    tick(3);
    check_lit("stop_g1_held", g1_ps_act, 1);
    tick(1);
    check_lit("stop_g1_drop", g1_ps_act, 0);
    check_lit("stop_idle", state, P_IDLE);
    idle_inputs();
    tick(1);

    // start and stop together: stop wins
    start_req = 1; stop_req = 1;
    tick(2);
    check_lit("start_stop_idle", state, P_IDLE);
    // start during an alarm is ignored without a fault
    stop_req = 0; g1_not_alarm = 0;
    tick(2);
    check_lit("start_alarm_idle", state, P_IDLE);
    check_lit("start_alarm_nofault", fault, 0);
    idle_inputs();
    tick(1);

    // G1 timeout
    start_req = 1;
    tick(13);
    check_lit("tmo_still_g1", state, P_G1);
    tick(1);
    check_lit("tmo_fault", fault, 1);
    check_lit("tmo_code", fault_code, 3);
    check_lit("tmo_g1_off", g1_ps_act, 0);
    start_req = 0; fault_clr = 1;
    tick(1);
    check_lit("tmo_clr_code", fault_code, 0);
    idle_inputs();
    tick(1);

    // alarm in RUN
    start_req = 1; g1_ok_n = 0; an_th_ready_n = 0; an_ok_n = 0;
    tick(8);
    check_lit("alm_run", state, P_RUN);
    start_req = 0; an_not_alarm = 0;
    tick(1);
    check_lit("alm_fault", fault, 1);
    check_lit("alm_code", fault_code, 2);
    check_lit("alm_an_off", an_ps_act, 0);
    fault_clr = 1;
    tick(1);
    check_lit("alm_clr_ignored", state, P_FLT);
    fault_clr = 0; an_not_alarm = 1;
    tick(1);
    fault_clr = 1;
    tick(1);
    check_lit("alm_clr_idle", state, P_IDLE);
    check_lit("alm_clr_code", fault_code, 0);
    idle_inputs();
    tick(1);

    // threshold not ready, then first-fault latch
    start_req = 1; g1_ok_n = 0; an_th_ready_n = 1; an_ok_n = 1;
    tick(7);
    check_lit("th_code", fault_code, 4);
    start_req = 0; g1_not_alarm = 0;
    tick(2);
    check_lit("th_latched", fault_code, 4);
    g1_not_alarm = 1; fault_clr = 1;
    tick(1);
    check_lit("th_clr", state, P_IDLE);
    idle_inputs();
    tick(1);

    // reset during AN_ON
    start_req = 1; g1_ok_n = 0; an_th_ready_n = 0; an_ok_n = 1;
    tick(8);
    check_lit("rst_an_on", state, P_AN);
    reset = 0; start_req = 0;
    tick(1);
    check_lit("rst_state", state, P_IDLE);
    check_lit("rst_g1", g1_ps_act, 0);
    check_lit("rst_an", an_ps_act, 0);
    reset = 1;
    idle_inputs();
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/rpsc_hv_sequencer.md
Name: rpsc_hv_sequencer

Overview:
- Power-up/power-down sequencer for the RPSC G1 grid supply and anode supply.
- Drives the G1_PS_ACT and AN_PS_ACT enables into the card-2 interlock logic.
- Consumes card-2 status returns (alarm, G1 OK, anode threshold-ready, anode OK) to step through G1 on, settle, anode on, run and controlled shutdown.
- Latches the first fault, with a code, until an operator clear.

Parameters:
- CNT_W, 4: width of the shared phase counter; every count parameter must be < 2**CNT_W.
- G1_TIMEOUT, 12: max cycles in G1_ON waiting for g1_ok_n=0.
- SETTLE, 4: cycles G1 must stay OK before the anode is enabled.
- AN_TIMEOUT, 14: max cycles in AN_ON waiting for an_ok_n=0.
- AN_OFF_DLY, 3: anode discharge cycles before G1 is dropped.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- start_req  in  1  level request to power up
- stop_req  in  1  level request to power down
- fault_clr  in  1  operator fault acknowledge
- g1_not_alarm  in  1  card-2 G1 alarm chain; 0 = alarm
- an_not_alarm  in  1  card-2 anode alarm chain; 0 = alarm
- g1_ok_n  in  1  0 = G1 OK (card-2 2 s qualifier expired)
- an_th_ready_n  in  1  0 = anode threshold ready
- an_ok_n  in  1  0 = anode OK
- g1_ps_act  out  1  G1 supply enable
- an_ps_act  out  1  anode supply enable
- hv_ready  out  1  high only in RUN
- fault  out  1  high only in FAULT
- fault_code  out  3  first-fault code
- state  out  3  current state, for debug

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-low.
- All outputs are registered and update the cycle after the sampling edge.
- Reset state: IDLE. g1_ps_act=0, an_ps_act=0, hv_ready=0, fault=0, fault_code=NONE, counter=0.
- A reset asserted mid-sequence drops both enables on the next edge.
- Fault codes: 0 NONE, 1 ALARM_G1, 2 ALARM_AN, 3 G1_TMO, 4 TH_NRDY, 5 AN_TMO, 6 G1_LOST, 7 AN_LOST.
- Counter: clears on every state entry, increments each cycle, saturates at all-ones.
- Event priority in every non-IDLE, non-FAULT state: alarm > timeout/loss > stop_req > progress.
  - Alarm: ALARM_G1 is checked before ALARM_AN.
  - On any alarm, the next state is FAULT and both enables drop on the same edge.

State transitions:
- IDLE: enables 0. If start_req=1 and both not_alarm=1 → G1_ON. start_req while an alarm is active is ignored (no fault raised).
- G1_ON: g1_ps_act=1.
  - g1_ok_n=0 → G1_SETTLE.
  - Counter reaches G1_TIMEOUT → FAULT with G1_TMO.
  - stop_req → IDLE.
- G1_SETTLE: g1_ps_act=1.
  - g1_ok_n=1 → FAULT with G1_LOST.
  - Counter reaches SETTLE: if an_th_ready_n=0 → AN_ON, else → FAULT with TH_NRDY.
  - stop_req → IDLE.
- AN_ON: both enables 1.
  - an_ok_n=0 → RUN.
  - Counter reaches AN_TIMEOUT → FAULT with AN_TMO.
  - g1_ok_n=1 → FAULT with G1_LOST.
  - stop_req → AN_OFF.
- RUN: both enables 1, hv_ready=1.
  - g1_ok_n=1 → FAULT with G1_LOST.
  - an_ok_n=1 → FAULT with AN_LOST.
  - stop_req → AN_OFF.
- AN_OFF: an_ps_act=0, g1_ps_act=1. Counter reaches AN_OFF_DLY → IDLE. Alarms still force FAULT.
- FAULT: enables 0, fault=1, fault_code holds the first code; later faults do not overwrite it.
  - fault_clr=1 with both not_alarm=1 → IDLE and fault_code=NONE.
  - fault_clr while an alarm is active is ignored.

Boundary cases:
- start_req and stop_req both high in IDLE: stop wins, stay IDLE.
- A timeout and a progress condition in the same cycle: timeout wins.

Decomposition:
- Package rpsc_seq_pkg holds:
  - state_e: IDLE, G1_ON, G1_SETTLE, AN_ON, RUN, AN_OFF, FAULT.
  - fault_e: the 3-bit codes above.
- One sub-module, rpsc_seq_counter: saturating CNT_W counter with clr and a terminal-compare output hit(target).

Test Plan:
- Nominal bring-up:
  - Stimulus: start_req=1 at cycle 0; g1_ok_n→0 at cycle 5; an_th_ready_n=0; an_ok_n→0 two cycles after an_ps_act rises.
  - Response: g1_ps_act=1 at cycle 1; an_ps_act=1 at G1_SETTLE entry + SETTLE + 1 cycles; hv_ready=1 one cycle after an_ok_n falls.
- G1 timeout:
  - Stimulus: start_req=1; g1_ok_n held 1.
  - Response: FAULT with fault_code=3 after 12 cycles in G1_ON; g1_ps_act=0.
- Alarm in RUN:
  - Stimulus: an_not_alarm=0 while in RUN.
  - Response: next edge gives both enables 0, fault=1, fault_code=2. Then fault_clr=1 while the alarm persists → stays FAULT. Alarm released, then fault_clr → IDLE, fault_code=0.
- Controlled stop:
  - Stimulus: stop_req in RUN.
  - Response: an_ps_act=0 next cycle; g1_ps_act held for AN_OFF_DLY=3 cycles, then 0; state=IDLE.
- First-fault latch and thresholds:
  - Stimulus: an_th_ready_n=1 at settle end.
  - Response: fault_code=4. A subsequent alarm while in FAULT does not change fault_code.
- Reset mid-operation:
  - Stimulus: reset=0 during AN_ON.
  - Response: all outputs 0 and state=IDLE on the next edge.
